// File: rtl/link_sw_pkg.sv
// Shared types and helpers for the link-layer request/ack switches.
package link_sw_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    localparam int IDXW_MAX  = 4;
    localparam int CODEW_DEF = 16;

    function automatic int idxw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [IDXW_MAX-1:0]  idx;
        logic [CODEW_DEF-1:0] code;
    } entry_t;

endpackage

// File: rtl/link_req_fifo.sv
// Single-clock FIFO of switch entries with an occupancy count.
module link_req_fifo
    import link_sw_pkg::*;
#(
    parameter type T      = entry_t,
    parameter int  AWIDTH = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              dout,
    output logic [AWIDTH:0] cnt
);

    localparam int DEPTH = 1 << AWIDTH;

    T mem [DEPTH];
    logic [AWIDTH-1:0] wr;
    logic [AWIDTH-1:0] rd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop)  rd <= rd + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end

    assign dout = mem[rd];

endmodule

// File: rtl/link_req_arbsw.sv
// N-client request/ack switch with queued grants and indexed ack routing.
// Optional counters enabled by LINK_REQ_ARBSW_STATS_EN.
module link_req_arbsw
    import link_sw_pkg::*;
#(
    parameter int NCLIENT = 4,
    parameter int CODEW   = 16,
    parameter int TXW     = 8,
    parameter int AWIDTH  = 5,
    parameter int RR      = PRIO_FIXED
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCLIENT-1:0]         cl_request,
    input  logic [NCLIENT*CODEW-1:0]   cl_requestcode,
    output logic [NCLIENT-1:0]         cl_requestacpt,
    output logic [NCLIENT-1:0]         cl_ack,
    output logic [CODEW-1:0]           ackcode,
    input  logic [NCLIENT*TXW-1:0]     cl_txdata,
    output logic                       up_request,
    input  logic                       up_ack,
    output logic [TXW-1:0]             up_txdata,
    output logic [$clog2(NCLIENT)-1:0] up_ackidx,
`ifdef LINK_REQ_ARBSW_STATS_EN
    output logic [AWIDTH:0]            reqcnt,
    output logic [15:0]                drop_cnt,
    output logic [NCLIENT*16-1:0]      grant_cnt
`else
    output logic [AWIDTH:0]            reqcnt
`endif
);

    localparam int IW    = idxw(NCLIENT);
    localparam int DEPTH = 1 << AWIDTH;

    typedef struct packed {
        logic [IW-1:0]    idx;
        logic [CODEW-1:0] code;
    } ent_t;

    logic          pop;
    logic          accept;
    logic          found;
    logic          ackvalid;
    logic [IW-1:0] gidx;
    logic [IW-1:0] rr_ptr;
    int            j;
    ent_t          din;
    ent_t          dout;

    // Search order starts at rr_ptr in round-robin mode, else at 0.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        j     = 0;
        for (int i = 0; i < NCLIENT; i++) begin
            j = (RR == PRIO_RR) ? int'(rr_ptr) + i : i;
            if (j >= NCLIENT) j = j - NCLIENT;
            if (!found && cl_request[j]) begin
                found = 1'b1;
                gidx  = IW'(j);
            end
        end
    end

    assign pop    = up_ack && (reqcnt != '0);
    assign accept = reset && found &&
                    ((reqcnt != (AWIDTH+1)'(DEPTH)) || pop);

    always_comb begin
        cl_requestacpt = '0;
        if (accept) cl_requestacpt[gidx] = 1'b1;
    end

    assign up_request = accept;
    assign din.idx    = gidx;
    assign din.code   = cl_requestcode[int'(gidx)*CODEW +: CODEW];

    link_req_fifo #(
        .T      (ent_t),
        .AWIDTH (AWIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .cnt   (reqcnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            cl_ack    <= '0;
            ackcode   <= '0;
            up_ackidx <= '0;
            ackvalid  <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            cl_ack <= '0;
            if (pop) begin
                cl_ack[dout.idx] <= 1'b1;
                ackcode          <= dout.code;
                up_ackidx        <= dout.idx;
                ackvalid         <= 1'b1;
            end
            if (RR == PRIO_RR && accept)
                rr_ptr <= (int'(gidx) == NCLIENT-1) ? '0 : gidx + 1'b1;
        end
    end

    assign up_txdata = ackvalid ?
                       cl_txdata[int'(up_ackidx)*TXW +: TXW] : '0;

`ifdef LINK_REQ_ARBSW_STATS_EN
    logic [15:0] gcnt [NCLIENT];

    // With reset high, a found-but-refused request means the queue was full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
            for (int i = 0; i < NCLIENT; i++) gcnt[i] <= '0;
        end else begin
            if (found && !accept && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
            if (accept && gcnt[gidx] != '1)
                gcnt[gidx] <= gcnt[gidx] + 1'b1;
        end
    end

    for (genvar g = 0; g < NCLIENT; g++) begin : g_gc
        assign grant_cnt[g*16 +: 16] = gcnt[g];
    end
`endif

endmodule

// File: tb/tb_link_req_arbsw.sv
// Bench for link_req_arbsw: fixed and round-robin instances, shared stimulus.
module tb_link_req_arbsw;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] codes;
    logic [31:0] txd;
    logic        up_ack;

    logic [3:0]  acpt   [2];
    logic [3:0]  ack    [2];
    logic [15:0] ackcode[2];
    logic        upreq  [2];
    logic [7:0]  uptx   [2];
    logic [1:0]  upidx  [2];
    logic [2:0]  cnt    [2];
`ifdef LINK_REQ_ARBSW_STATS_EN
    logic [15:0] drop   [2];
    logic [63:0] gcnt   [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    link_req_arbsw #(
        .NCLIENT(4), .CODEW(16), .TXW(8), .AWIDTH(2), .RR(0)
    ) u_fix (
        .clk(clk), .reset(rst), .cl_request(req),
        .cl_requestcode(codes), .cl_requestacpt(acpt[0]),
        .cl_ack(ack[0]), .ackcode(ackcode[0]), .cl_txdata(txd),
        .up_request(upreq[0]), .up_ack(up_ack),
        .up_txdata(uptx[0]), .up_ackidx(upidx[0]),
        .reqcnt(cnt[0])
`ifdef LINK_REQ_ARBSW_STATS_EN
        , .drop_cnt(drop[0]), .grant_cnt(gcnt[0])
`endif
    );

    link_req_arbsw #(
        .NCLIENT(4), .CODEW(16), .TXW(8), .AWIDTH(2), .RR(1)
    ) u_rr (
        .clk(clk), .reset(rst), .cl_request(req),
        .cl_requestcode(codes), .cl_requestacpt(acpt[1]),
        .cl_ack(ack[1]), .ackcode(ackcode[1]), .cl_txdata(txd),
        .up_request(upreq[1]), .up_ack(up_ack),
        .up_txdata(uptx[1]), .up_ackidx(upidx[1]),
        .reqcnt(cnt[1])
`ifdef LINK_REQ_ARBSW_STATS_EN
        , .drop_cnt(drop[1]), .grant_cnt(gcnt[1])
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {idx, code} per instance.
    logic [19:0] mq [2][$];
    int          rrp  [2];
    logic [3:0]  mack [2];
    logic [15:0] mcode[2];
    int          midx [2];
    bit          mval [2];
    int          mdrop[2];
    int          mgr  [2][4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int winner(input int m);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m == 1) ? (rrp[m] + k) % 4 : k;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit mpop(input int m);
        return rst && up_ack && mq[m].size() != 0;
    endfunction

    function automatic bit macc(input int m);
        return rst && winner(m) >= 0 &&
               (mq[m].size() < DEPTH || mpop(m));
    endfunction

    task automatic model_check();
        for (int m = 0; m < 2; m++) begin
            string s;
            logic [3:0] ea;
            logic [7:0] et;
            s  = (m == 1) ? "rr" : "fix";
            ea = macc(m) ? (4'd1 << winner(m)) : 4'd0;
            et = mval[m] ? txd[midx[m]*8 +: 8] : 8'd0;
            chk({"acpt_", s}, 32'(acpt[m]), 32'(ea));
            chk({"upreq_", s}, 32'(upreq[m]), 32'(macc(m)));
            chk({"reqcnt_", s}, 32'(cnt[m]), 32'(mq[m].size()));
            chk({"ack_", s}, 32'(ack[m]), 32'(mack[m]));
            chk({"ackcode_", s}, 32'(ackcode[m]), 32'(mcode[m]));
            chk({"ackidx_", s}, 32'(upidx[m]), 32'(midx[m]));
            chk({"uptx_", s}, 32'(uptx[m]), 32'(et));
`ifdef LINK_REQ_ARBSW_STATS_EN
            chk({"drop_", s}, 32'(drop[m]), 32'(mdrop[m]));
            for (int g = 0; g < 4; g++)
                chk({"gcnt_", s}, 32'(gcnt[m][g*16 +: 16]),
                    32'(mgr[m][g]));
`endif
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int w;
            bit p, a;
            logic [19:0] e;
            if (!rst) begin
                mq[m].delete();
                rrp[m] = 0; mack[m] = 0; mcode[m] = 0;
                midx[m] = 0; mval[m] = 0; mdrop[m] = 0;
                for (int g = 0; g < 4; g++) mgr[m][g] = 0;
            end else begin
                w = winner(m);
                p = mpop(m);
                a = macc(m);
                mack[m] = 0;
                if (p) begin
                    e = mq[m].pop_front();
                    mack[m]  = 4'd1 << e[19:16];
                    mcode[m] = e[15:0];
                    midx[m]  = int'(e[19:16]);
                    mval[m]  = 1'b1;
                end
                if (a) begin
                    mq[m].push_back({4'(w), codes[w*16 +: 16]});
                    if (m == 1) rrp[m] = (w + 1) % 4;
                    if (mgr[m][w] < 65535) mgr[m][w]++;
                end
                if (w >= 0 && !a && mdrop[m] < 65535) mdrop[m]++;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        #1;
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        ack;
        logic [3:0]  acpt;
        int          cnt;
        logic [3:0]  eack;
        logic [15:0] code;
    } vec_t;

    vec_t       tbl [17];
    logic [3:0] rrexp [6];

    initial begin
        for (int m = 0; m < 2; m++) begin
            rrp[m] = 0; mack[m] = 0; mcode[m] = 0;
            midx[m] = 0; mval[m] = 0; mdrop[m] = 0;
            for (int g = 0; g < 4; g++) mgr[m][g] = 0;
        end

        tbl[0]  = '{4'b1010, 1'b0, 4'b0010, 0, 4'b0000, 16'h0000};
        tbl[1]  = '{4'b1000, 1'b0, 4'b1000, 1, 4'b0000, 16'h0000};
        tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 2, 4'b0000, 16'h0000};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 3, 4'b0000, 16'h0000};
        tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 2, 4'b0010, 16'h0806};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 2, 4'b0000, 16'h0806};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1, 4'b1000, 16'h0800};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 0, 4'b0100, 16'h0011};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 0, 4'b0000, 16'h0011};
        tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 0, 4'b0000, 16'h0011};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1, 4'b0000, 16'h0011};
        tbl[11] = '{4'b0001, 1'b0, 4'b0001, 1, 4'b0000, 16'h0011};
        tbl[12] = '{4'b0001, 1'b0, 4'b0001, 2, 4'b0000, 16'h0011};
        tbl[13] = '{4'b0001, 1'b0, 4'b0001, 3, 4'b0000, 16'h0011};
        tbl[14] = '{4'b0001, 1'b0, 4'b0000, 4, 4'b0000, 16'h0011};
        tbl[15] = '{4'b0001, 1'b1, 4'b0001, 4, 4'b0000, 16'h0011};
        tbl[16] = '{4'b0000, 1'b0, 4'b0000, 4, 4'b0100, 16'h0011};
        rrexp = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};

        rst    = 1'b0;
        req    = 4'b1111;
        up_ack = 1'b0;
        codes  = {16'h0800, 16'h0011, 16'h0806, 16'h1234};
        txd    = 32'hD3C2B1A0;

        repeat (2) begin
            settle();
            chk("rst_acpt", 32'(acpt[0]), 0);
            chk("rst_upreq", 32'(upreq[0]), 0);
            chk("rst_reqcnt", 32'(cnt[0]), 0);
            chk("rst_ack", 32'(ack[0]), 0);
            chk("rst_uptx", 32'(uptx[0]), 0);
            advance();
        end
        rst = 1'b1;
        req = 4'b0000;

        for (int i = 0; i < 17; i++) begin
            req    = tbl[i].req;
            up_ack = tbl[i].ack;
            settle();
            chk($sformatf("tbl%0d_acpt", i), 32'(acpt[0]),
                32'(tbl[i].acpt));
            chk($sformatf("tbl%0d_upreq", i), 32'(upreq[0]),
                32'(|tbl[i].acpt));
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt[0]),
                32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ack", i), 32'(ack[0]),
                32'(tbl[i].eack));
            chk($sformatf("tbl%0d_code", i), 32'(ackcode[0]),
                32'(tbl[i].code));
            advance();
        end

        req = 4'b0001;
        up_ack = 1'b0;
`ifdef LINK_REQ_ARBSW_STATS_EN
        settle();
        chk("drop_after_tbl", 32'(drop[0]), 1);
`endif
        repeat (3) begin
            settle();
            advance();
        end
`ifdef LINK_REQ_ARBSW_STATS_EN
        settle();
        chk("drop_full3", 32'(drop[0]), 4);
`endif

        req = 4'b0000;
        rst = 1'b0;
        settle(); advance();
        rst = 1'b1;
        req = 4'b0100; settle(); advance();
        req = 4'b0001; settle(); advance();
        req = 4'b0010; settle(); advance();
        req = 4'b0000; up_ack = 1'b1; settle(); advance();
        up_ack = 1'b0;
        settle();
        chk("ackq_ack", 32'(ack[0]), 32'h4);
        chk("ackq_code", 32'(ackcode[0]), 32'h0011);
        chk("ackq_idx", 32'(upidx[0]), 2);
        chk("ackq_tx", 32'(uptx[0]), 32'hC2);
        advance();
        settle();
        chk("ackq_one", 32'(ack[0]), 0);
        advance();

        req = 4'b1000; settle(); advance();
        req = 4'b0000;
        settle();
        chk("mid_cnt3", 32'(cnt[0]), 3);
        rst = 1'b0;
        advance();
        rst = 1'b1;
        settle();
        chk("mid_cnt", 32'(cnt[0]), 0);
        chk("mid_code", 32'(ackcode[0]), 0);
        chk("mid_tx", 32'(uptx[0]), 0);
        chk("mid_ack", 32'(ack[0]), 0);
        up_ack = 1'b1;
        advance();
        up_ack = 1'b0;
        settle();
        chk("mid_noack", 32'(ack[0]), 0);
        chk("mid_noack_rr", 32'(ack[1]), 0);
        advance();

        req = 4'b0111;
        up_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk($sformatf("rr%0d", i), 32'(acpt[1]), 32'(rrexp[i]));
            advance();
        end

        for (int i = 0; i < 4000; i++) begin
            req    = 4'($urandom_range(0, 15));
            up_ack = ($urandom_range(0, 2) != 0);
            rst    = ($urandom_range(0, 127) != 0);
            codes  = {$urandom, $urandom};
            txd    = $urandom;
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/link_req_arbsw.md
Name: link_req_arbsw

Overview:
- Generalised N-client request/ack switch for the protocol-stack link layers (ethernet, ipv4, udp, icmp levels).
- Arbitrates single-cycle requests from NCLIENT clients and queues the granted {client index, request code} pairs in an internal FIFO.
- Pops one entry per upstream ack, returns a registered ack to the owning client, and steers that client's tx data upstream.
- Differences from the fixed 2/3-client switches it replaces: routing by stored index rather than code compare; full back-pressure; selectable round-robin priority.

Parameters:
- NCLIENT, 4, number of downstream clients (2..16)
- CODEW, 16, request/ack code width
- TXW, 8, per-client tx data width
- AWIDTH, 5, FIFO address width; DEPTH = 2**AWIDTH entries
- RR, 0, 0 = fixed priority (index 0 highest), 1 = round robin

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cl_request  in  NCLIENT  per-client request pulse
- cl_requestcode  in  NCLIENT*CODEW  per-client code, client i at [i*CODEW +: CODEW]
- cl_requestacpt  out  NCLIENT  one-hot grant, combinational
- cl_ack  out  NCLIENT  one-hot ack, registered
- ackcode  out  CODEW  code of last ack, shared by all clients
- cl_txdata  in  NCLIENT*TXW  per-client tx data
- up_request  out  1  pulses high on each accepted request
- up_ack  in  1  upstream consumed one request
- up_txdata  out  TXW  tx data of the currently acked client
- up_ackidx  out  $clog2(NCLIENT)  index of the currently acked client
- reqcnt  out  AWIDTH+1  entries pending in the FIFO

Behaviour:
- Reset (reset==0 at posedge) clears:
  - FIFO pointers, reqcnt, ack register, ackcode, up_ackidx, rr pointer, ackvalid flag.
  - All outputs read 0 from the next cycle.
  - Reset mid-queue discards all entries; no ack is issued for them.
- Grant logic is combinational from cl_request and the state registers.
  - At most one bit of cl_requestacpt is set per cycle.
  - Nothing is granted while reset is low.
- Fixed mode (RR=0): the lowest-index requesting client wins.
- RR mode (RR=1): search starts at rr_ptr and wraps modulo NCLIENT. On a grant to client g, rr_ptr <= (g+1) mod NCLIENT.
- A losing client must hold its request; it is not latched.
- Accept condition: any request AND (reqcnt < DEPTH OR pop this cycle).
  - When the FIFO is full and there is no pop, cl_requestacpt is all zero and up_request is 0.
- Write: on accept, push {g, code_g} at the clock edge. up_request = accept, same cycle as cl_requestacpt.
- Pop: up_ack high AND reqcnt != 0.
  - up_ack while empty is ignored and reqcnt does not underflow.
  - Push into an empty FIFO with up_ack in the same cycle: the pop is ignored and the entry stays.
- reqcnt: +1 on push only, -1 on pop only, unchanged on both or neither. Range 0..DEPTH.
- Ack latency: a pop with up_ack in cycle t asserts cl_ack[idx] for exactly one cycle, in cycle t+1.
  - In that same edge: ackcode <= code, up_ackidx <= idx, ackvalid <= 1.
  - ackcode and up_ackidx hold until the next pop.
  - up_ack on consecutive cycles gives consecutive one-cycle acks in FIFO order.
- up_txdata = cl_txdata[up_ackidx] when ackvalid, else 0. It is a combinational mux.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH; full and empty are distinguished by reqcnt.

Optional Feature:
- LINK_REQ_ARBSW_STATS_EN
- Defined:
  - Adds output drop_cnt (16 bits): counts cycles where a request is present but refused because the FIFO is full. Saturates at 0xFFFF.
  - Adds output grant_cnt (NCLIENT*16 bits): per-client accepted requests, saturating.
  - Both counters clear on reset.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package link_sw_pkg holds:
  - clog2-based index width function.
  - Entry struct {idx, code}.
  - Mode constants PRIO_FIXED=0, PRIO_RR=1.
- Sub-module link_req_fifo: single-clock register/BRAM FIFO of entry structs with count output, used by this block and future switch levels.
- Arbiter stays inline.

Test Plan:
- Fixed mode, NCLIENT=4: clients 1 and 3 request together with codes 0x0806 and 0x0800 → only acpt[1] is set; client 3 holds and is granted next cycle; reqcnt 0→1→2.
- RR mode: clients 0,1,2 request continuously for 6 cycles → grant order 0,1,2,0,1,2.
- Queue 3 entries (idx 2, code 0x0011 first), then up_ack one cycle → cl_ack=4'b0100 for exactly one cycle one cycle later; ackcode=0x0011; up_ackidx=2; up_txdata=cl_txdata[2].
- AWIDTH=2: push 4 entries, then a 5th request without pop → acpt=0, up_request=0, reqcnt=4; the same request with up_ack → accepted and reqcnt stays 4.
- up_ack with empty FIFO → no cl_ack and reqcnt stays 0. Push and up_ack in the same cycle on an empty FIFO → reqcnt=1 and no ack.
- Reset low for one cycle with 3 entries queued → reqcnt=0, ackcode=0, up_txdata=0; a later up_ack produces no ack. With STATS_EN defined, a full-refused request increments drop_cnt by 1 per cycle.
